// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory target for the memory-stage load/store port.
//               Accepts one request at a time, waits a fixed number of
//               cycles, then performs a little-endian byte/half/word access
//               on an internal word array. It returns a held response with
//               an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         c_mem_aw    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int         c_idx_w     = ADDR_W - 2;
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]        r_cnt;
    logic              r_rsp_valid;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [31:0]       r_wdata;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_commit;
    logic              w_op_we;
    logic [ADDR_W-1:0] w_op_addr;
    logic [1:0]        w_op_size;
    logic              w_op_uns;
    logic [31:0]       w_op_wdata;
    logic [c_idx_w-1:0] w_index;
    logic [c_mem_aw-1:0] w_mem_idx;
    logic              w_range_err;
    logic              w_err;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_sel_byte;
    logic [15:0]       w_sel_half;
    logic [31:0]       w_load;
    logic [31:0]       w_lane_data;
    logic [3:0]        w_be;
    logic [31:0]       w_merged;
    logic              w_wr_en;

    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // With zero wait states the access happens on the accepting edge itself,
    // so the live request is used; otherwise the latched copy is used.
    assign w_op_we    = (r_state == S_IDLE) ? req_we       : r_we;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr     : r_addr;
    assign w_op_size  = (r_state == S_IDLE) ? req_size     : r_size;
    assign w_op_uns   = (r_state == S_IDLE) ? req_unsigned : r_uns;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata    : r_wdata;

    assign w_commit = ((r_state == S_IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd0));

    assign w_index     = w_op_addr[ADDR_W-1:2];
    assign w_mem_idx   = w_op_addr[c_mem_aw+1:2];
    assign w_range_err = {{(64-c_idx_w){1'b0}}, w_index} >= 64'(DEPTH_WORDS);

    // Misaligned, illegal-size and out-of-range accesses all flag an error.
    always_comb begin
        w_err = w_range_err;
        case (w_op_size)
            2'b00:   w_err = w_range_err;
            2'b01:   w_err = w_range_err || w_op_addr[0];
            2'b10:   w_err = w_range_err || (w_op_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
    end

    assign w_rd_word = w_range_err ? 32'd0 : r_mem[w_mem_idx];

    // Pick the addressed byte lane out of the stored word.
    always_comb begin
        w_sel_byte = w_rd_word[7:0];
        case (w_op_addr[1:0])
            2'b00:   w_sel_byte = w_rd_word[7:0];
            2'b01:   w_sel_byte = w_rd_word[15:8];
            2'b10:   w_sel_byte = w_rd_word[23:16];
            default: w_sel_byte = w_rd_word[31:24];
        endcase
    end

    assign w_sel_half = w_op_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    // Extend the selected lane(s) to 32 bits; word loads pass straight through.
    always_comb begin
        w_load = w_rd_word;
        case (w_op_size)
            2'b00:   w_load = w_op_uns ? {24'd0, w_sel_byte} : {{24{w_sel_byte[7]}}, w_sel_byte};
            2'b01:   w_load = w_op_uns ? {16'd0, w_sel_half} : {{16{w_sel_half[15]}}, w_sel_half};
            default: w_load = w_rd_word;
        endcase
    end

    // Replicate store data across lanes and build the byte enables.
    always_comb begin
        w_lane_data = w_op_wdata;
        w_be        = 4'b0000;
        case (w_op_size)
            2'b00: begin
                w_lane_data = {4{w_op_wdata[7:0]}};
                w_be        = 4'b0001 << w_op_addr[1:0];
            end
            2'b01: begin
                w_lane_data = {2{w_op_wdata[15:0]}};
                w_be        = w_op_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_lane_data = w_op_wdata;
                w_be        = 4'b1111;
            end
            default: begin
                w_lane_data = w_op_wdata;
                w_be        = 4'b0000;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = w_be[gi] ? w_lane_data[8*gi +: 8] : w_rd_word[8*gi +: 8];
    end

    assign w_wr_en = w_commit && w_op_we && !w_err;

    // Array write at the commit point; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            r_mem[w_mem_idx] <= w_merged;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = rst;
                if (req_valid && rst) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request on acceptance for use during the wait states.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
        end
    end

    // Wait counter and registered response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= c_wait_load;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_err       <= w_err;
                r_rdata     <= (w_err || w_op_we) ? 32'd0 : w_load;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A byte-array model
//               predicts every response and its cycle of arrival. A second
//               instance with three wait states exercises reset mid-wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WAIT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, req_we, req_unsigned;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_size;

    logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [1:0]  b_req_size;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_CYCLES(WAIT1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired t=%0t", name, $time);
    endtask

    // Byte-addressed reference memory and access rules.
    logic [7:0] mb [DEPTH*4];

    function automatic void model_exec(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                       input logic uns, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        n  = 1 << sz;
        er = (sz == 2'd3) || ((a & 32'(n - 1)) != 32'd0) || ((a >> 2) >= 32'(DEPTH));
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int k = 0; k < n; k++) mb[a + 32'(k)] = wd[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v = v | (32'(mb[a + 32'(k)]) << (8*k));
                if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                rd = v;
            end
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: predicts outputs cycle by cycle from the request stream.
    logic        m_en = 1'b0, m_pend = 1'b0, m_rsp = 1'b0, m_zero = 1'b0;
    int          m_due = 0;
    logic        m_we, m_uns, e_err;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, e_rd;

    initial forever begin
        @(negedge clk);
        if (m_pend && cyc == m_due) begin
            model_exec(m_we, m_addr, m_size, m_uns, m_wdata, e_rd, e_err);
            m_pend = 1'b0;
            m_rsp  = 1'b1;
            m_zero = 1'b0;
        end
        if (m_en) begin
            chk("req_ready", 32'(req_ready), 32'(rst && !m_pend && !m_rsp));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            if (m_rsp) begin
                chk("rsp_rdata", rsp_rdata, e_rd);
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
            end else if (m_zero) begin
                chk("reset_rdata", rsp_rdata, 32'd0);
                chk("reset_err", 32'(rsp_err), 32'd0);
            end
        end
        if (!rst) begin
            m_pend = 1'b0;
            m_rsp  = 1'b0;
            m_zero = 1'b1;
            m_en   = 1'b1;
        end else if (m_rsp) begin
            if (rsp_ready) m_rsp = 1'b0;
        end else if (!m_pend && req_valid) begin
            m_we    = req_we;
            m_addr  = req_addr;
            m_size  = req_size;
            m_uns   = req_unsigned;
            m_wdata = req_wdata;
            m_pend  = 1'b1;
            m_due   = cyc + WAIT1 + 1;
        end
    end

    // One request on the WAIT_CYCLES=1 instance; lat counts cycles from acceptance.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                          input logic [31:0] wd, input int hold, input bit keep,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 20);
        if (!req_ready) timeout("accept");
        @(posedge clk); #1;
        if (keep) begin
            req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
        if (!rsp_valid) timeout("response");
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) begin @(posedge clk); #1; req_valid = 1'b0; end
        @(posedge clk); #1; req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    // One word request on the WAIT_CYCLES=3 instance.
    task automatic b_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = a; b_req_size = 2'd2;
        b_req_unsigned = 1'b0; b_req_wdata = wd;
        @(negedge clk);
        if (!b_req_ready) timeout("b_accept");
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!b_rsp_valid && lat < 40);
        if (!b_rsp_valid) timeout("b_response");
        rd = b_rsp_rdata;
        er = b_rsp_err;
        @(posedge clk); #1; b_rsp_ready = 1'b1;
        @(posedge clk); #1; b_rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] rd, a;
        logic        er;
        logic [1:0]  sz;
        int          lat, r;

        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D; rsp_ready = 1'b1;
        b_rst = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_size = 2'd2;
        b_req_unsigned = 1'b0; b_req_wdata = 32'd0; b_rsp_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 32'(w*4), 2'd2, 1'b0, $urandom, 0, 1'b0, rd, er, lat);

        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, 1'b0, rd, er, lat);
        chk("store_latency", 32'(lat), 32'd2);
        chk("store_err", 32'(er), 32'd0);
        chk("store_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("load_word", rd, 32'hDEADBEEF);

        do_req(1'b1, 32'h20, 2'd2, 1'b0, 32'h55667788, 0, 1'b0, rd, er, lat);
        do_req(1'b1, 32'h21, 2'd0, 1'b0, 32'h00000080, 0, 1'b0, rd, er, lat);
        do_req(1'b0, 32'h21, 2'd0, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("load_byte_signed", rd, 32'hFFFFFF80);
        do_req(1'b0, 32'h21, 2'd0, 1'b1, 32'd0, 0, 1'b0, rd, er, lat);
        chk("load_byte_unsigned", rd, 32'h00000080);
        do_req(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("word_after_byte", rd, 32'h55668088);
        do_req(1'b1, 32'h22, 2'd1, 1'b0, 32'h00001234, 0, 1'b0, rd, er, lat);
        do_req(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("word_after_half", rd, 32'h12348088);

        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 5, 1'b0, rd, er, lat);
        chk("backpressure_rdata", rd, 32'hDEADBEEF);

        do_req(1'b0, 32'h13, 2'd2, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("misaligned_word_err", 32'(er), 32'd1);
        chk("misaligned_word_rdata", rd, 32'd0);
        do_req(1'b1, 32'h30, 2'd2, 1'b0, 32'hA5A5A5A5, 0, 1'b0, rd, er, lat);
        do_req(1'b1, 32'h31, 2'd1, 1'b0, 32'h0000FFFF, 0, 1'b0, rd, er, lat);
        chk("misaligned_half_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h30, 2'd2, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("no_write_on_err", rd, 32'hA5A5A5A5);
        do_req(1'b0, 32'(DEPTH*4), 2'd2, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("range_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h80000010, 2'd2, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("high_bits_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("size3_err", 32'(er), 32'd1);

        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
        req_size = 2'd2; req_wdata = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, 1'b0, rd, er, lat);
        chk("no_write_in_reset", rd, 32'hDEADBEEF);

        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) begin
                req_addr = $urandom; req_we = 1'($urandom);
                rsp_ready = 1'($urandom);
                @(posedge clk); #1;
            end
            rsp_ready = 1'b0;
            r  = int'($urandom_range(0, 15));
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (r == 0) a = $urandom;
            else if (r == 1) a = 32'(DEPTH*4) + 32'($urandom_range(0, 15));
            else begin
                a = 32'($urandom_range(0, DEPTH*4 - 1));
                if (r > 4 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            end
            do_req(1'($urandom), a, sz, 1'($urandom), $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom), rd, er, lat);
            chk("random_latency", 32'(lat), 32'd2);
        end

        @(posedge clk); #1;
        b_rst = 1'b1;
        b_req(1'b1, 32'h40, 32'h11111111, rd, er, lat);
        chk("b_latency", 32'(lat), 32'd4);
        chk("b_store_err", 32'(er), 32'd0);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h40; b_req_size = 2'd2;
        b_req_wdata = 32'h22222222;
        @(negedge clk);
        chk("b_accept", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        b_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("b_no_rsp_after_reset", 32'(b_rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        b_req(1'b0, 32'h40, 32'd0, rd, er, lat);
        chk("b_store_dropped", rd, 32'h11111111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target side of the load/store request interface that the memory stage drives.
- Accepts one request at a time over a valid/ready handshake.
- Performs little-endian byte, half-word or word stores and loads (with sign/zero extension) into an internal word array after a programmable wait-state delay.
- Returns a held response with an error flag. It sits beside the memory stage in the processor model and stands in for the data memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = req_addr[ADDR_W-1:2]
ADDR_W, 32, request byte-address width
WAIT_CYCLES, 1, wait states between acceptance and response (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts the response
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  request was misaligned, out of range or illegal size

Behaviour:
- Reset (rst=0 at a clock edge):
  - state <= IDLE; rsp_valid, rsp_rdata, rsp_err <= 0; wait counter <= 0.
  - req_ready = (state==IDLE) && rst, so it is 0 while rst is low.
  - Array contents are not reset.
  - Reset mid-operation drops the pending request and any held response. A store not yet committed is never written.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/size/unsigned/wdata and compute the error. If WAIT_CYCLES=0 go to RESP at the next edge; otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle; at counter=0 go to RESP.
  - RESP: rsp_valid=1, with rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready. On that edge, go to IDLE and clear rsp_valid.
- Commit point: the array access (store write or load read) happens on the edge that enters RESP; the outputs are registered on that same edge.
  - Latency from the accepting edge to rsp_valid is WAIT_CYCLES+1 cycles.
  - Minimum occupancy is WAIT_CYCLES+2 cycles per request.
  - No new request is accepted in the cycle a response is consumed.
- Error conditions (rsp_err=1, no array write, rsp_rdata=0):
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= DEPTH_WORDS, or any address bits above the index nonzero.
- Stores use byte enables from addr[1:0] and size.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes addr[1]*2+{0,1} get wdata[15:0].
  - Word: all lanes.
  - Other lanes are untouched. rsp_rdata=0.
- Loads select the lane(s) by addr[1:0], then sign- or zero-extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- While not in IDLE, req_* inputs are ignored; req_valid may stay high without effect.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles with req_valid=1. Required: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and no write occurs. After rst=1: req_ready=1.
- Word store then load (WAIT_CYCLES=1): store addr 0x10, data 0xDEADBEEF; rsp_valid appears 2 cycles after acceptance with rsp_err=0, rsp_rdata=0. Then load word 0x10 -> rsp_rdata=0xDEADBEEF.
- Sub-word extension:
  - Store byte 0x80 to 0x21, then load byte 0x21 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Load word 0x20 -> byte 1 = 0x80, other lanes unchanged.
  - Store half 0x1234 to 0x22, then load word 0x20 -> [31:16]=0x1234.
- Backpressure: load response held with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout. Raise rsp_ready -> state is IDLE one cycle later.
- Errors:
  - Word load at 0x13 -> rsp_err=1, rdata=0.
  - Half store at 0x31 -> rsp_err=1, and a later word load of 0x30 returns its old value.
  - Word load at byte address DEPTH_WORDS*4 -> rsp_err=1.
  - size=11 -> rsp_err=1.
- Reset mid-operation: accept a store to 0x40 with WAIT_CYCLES=3 and drive rst=0 during WAIT. Required: rsp_valid stays 0, and after reset a load of 0x40 returns its pre-store contents.
